// File: rtl/ula_mdu.sv
// Registered ALU with iterative RV32M-class multiply/divide and a start/ready/done handshake.
// Optional macro ULA_FAST_MUL_EN: single-cycle combinational multiply instead of shift-add.
module ula_mdu #(
  parameter int WIDTH     = 32,
  parameter int LUI_SHIFT = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [4:0]       select_ula,
  input  logic [WIDTH-1:0] data1_in,
  input  logic [WIDTH-1:0] data2_in,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] data_out,
  output logic             zero,
  output logic             illegal_op
);

  localparam int SW = $clog2(WIDTH);
  localparam logic [SW-1:0] LAST_CNT = SW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
`ifdef ULA_FAST_MUL_EN
  localparam bit FAST_MUL = 1'b1;
`else
  localparam bit FAST_MUL = 1'b0;
`endif

  localparam logic [4:0] OP_ADD = 5'h01, OP_SUB = 5'h02, OP_SLL = 5'h03, OP_SLT = 5'h04,
                         OP_SLTU = 5'h05, OP_SRL = 5'h06, OP_SRA = 5'h07, OP_XOR = 5'h08,
                         OP_OR = 5'h09, OP_AND = 5'h0A, OP_LUI = 5'h0B,
                         OP_MUL = 5'h10, OP_MULH = 5'h11, OP_MULHSU = 5'h12, OP_MULHU = 5'h13,
                         OP_DIV = 5'h14, OP_DIVU = 5'h15, OP_REM = 5'h16, OP_REMU = 5'h17;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [4:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, mcand_q, mcand_d, dout_q, dout_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [SW-1:0]      cnt_q, cnt_d;
  logic               sa_q, sa_d, sb_q, sb_d, done_q, done_d, zero_q, zero_d, ill_q, ill_d;

  // Acceptance-time decode on the raw inputs
  logic             in_is_mul, in_is_div, in_sa, in_sb, in_div_zero, in_div_ovf;
  logic [WIDTH-1:0] mag_a_in, mag_b_in;
  assign in_is_mul   = (select_ula[4:2] == 3'b100);
  assign in_is_div   = (select_ula[4:2] == 3'b101);
  assign in_sa       = data1_in[WIDTH-1] & (select_ula == OP_MUL || select_ula == OP_MULH ||
                       select_ula == OP_MULHSU || select_ula == OP_DIV || select_ula == OP_REM);
  assign in_sb       = data2_in[WIDTH-1] & (select_ula == OP_MUL || select_ula == OP_MULH ||
                       select_ula == OP_DIV || select_ula == OP_REM);
  assign mag_a_in    = in_sa ? -data1_in : data1_in;
  assign mag_b_in    = in_sb ? -data2_in : data2_in;
  assign in_div_zero = (data2_in == '0);
  assign in_div_ovf  = (select_ula == OP_DIV || select_ula == OP_REM) &&
                       (data1_in == MIN_NEG) && (data2_in == '1);

  // One shift-add / restoring-divide step per cycle on the shared accumulator
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] mul_next, div_next, prod_fix, fa, fb, fast_prod;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
  assign mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
  assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, mcand_q};
  assign div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                     : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
  assign prod_fix  = (sa_q ^ sb_q) ? -acc_q : acc_q;
  assign quo_fix   = (sa_q ^ sb_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix   = sa_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  assign fa        = {{WIDTH{sa_q}}, a_q};
  assign fb        = {{WIDTH{sb_q}}, b_q};
  assign fast_prod = fa * fb;

  logic [SW-1:0]      shamt;
  logic [2*WIDTH-1:0] mul_full;
  logic [WIDTH-1:0]   final_res;
  logic               final_ill;
  assign shamt    = b_q[SW-1:0];
  assign mul_full = FAST_MUL ? fast_prod : prod_fix;

  always_comb begin
    final_res = '0;
    final_ill = 1'b0;
    case (op_q)
      OP_ADD:  final_res = a_q + b_q;
      OP_SUB:  final_res = a_q - b_q;
      OP_SLL:  final_res = a_q << shamt;
      OP_SLT:  final_res = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      OP_SLTU: final_res = {{(WIDTH-1){1'b0}}, (a_q < b_q)};
      OP_SRL:  final_res = a_q >> shamt;
      OP_SRA:  final_res = $unsigned($signed(a_q) >>> shamt);
      OP_XOR:  final_res = a_q ^ b_q;
      OP_OR:   final_res = a_q | b_q;
      OP_AND:  final_res = a_q & b_q;
      OP_LUI:  final_res = b_q << LUI_SHIFT;
      OP_MUL:  final_res = mul_full[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: final_res = mul_full[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU: begin
        if (b_q == '0)                                           final_res = '1;
        else if (op_q == OP_DIV && a_q == MIN_NEG && b_q == '1)  final_res = a_q;
        else                                                     final_res = quo_fix;
      end
      OP_REM, OP_REMU: begin
        if (b_q == '0)                                           final_res = a_q;
        else if (op_q == OP_REM && a_q == MIN_NEG && b_q == '1)  final_res = '0;
        else                                                     final_res = rem_fix;
      end
      default: final_ill = 1'b1;
    endcase
  end

  // DONE spends one cycle registering the result and one cycle presenting done
  always_comb begin
    state_d = state_q;  op_d = op_q;  a_d = a_q;  b_d = b_q;
    sa_d = sa_q;  sb_d = sb_q;  mcand_d = mcand_q;  acc_d = acc_q;  cnt_d = cnt_q;
    done_d = done_q;  dout_d = dout_q;  zero_d = zero_q;  ill_d = ill_q;
    case (state_q)
      S_IDLE: begin
        done_d = 1'b0;
        if (start) begin
          op_d = select_ula;  a_d = data1_in;  b_d = data2_in;
          sa_d = in_sa;  sb_d = in_sb;  cnt_d = '0;
          if (in_is_mul && !FAST_MUL) begin
            mcand_d = mag_a_in;
            acc_d   = {{WIDTH{1'b0}}, mag_b_in};
            state_d = S_MUL;
          end else if (in_is_div && !in_div_zero && !in_div_ovf) begin
            mcand_d = mag_b_in;
            acc_d   = {{WIDTH{1'b0}}, mag_a_in};
            state_d = S_DIV;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_MUL: begin
        acc_d = mul_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) state_d = S_DONE;
      end
      S_DIV: begin
        acc_d = div_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) state_d = S_DONE;
      end
      S_DONE: begin
        if (!done_q) begin
          done_d = 1'b1;
          dout_d = final_res;
          zero_d = (final_res == '0);
          ill_d  = final_ill;
        end else begin
          done_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;  op_q <= '0;  a_q <= '0;  b_q <= '0;
      sa_q <= 1'b0;  sb_q <= 1'b0;  mcand_q <= '0;  acc_q <= '0;  cnt_q <= '0;
      done_q <= 1'b0;  dout_q <= '0;  zero_q <= 1'b1;  ill_q <= 1'b0;
    end else begin
      state_q <= state_d;  op_q <= op_d;  a_q <= a_d;  b_q <= b_d;
      sa_q <= sa_d;  sb_q <= sb_d;  mcand_q <= mcand_d;  acc_q <= acc_d;  cnt_q <= cnt_d;
      done_q <= done_d;  dout_q <= dout_d;  zero_q <= zero_d;  ill_q <= ill_d;
    end
  end

  assign ready      = (state_q == S_IDLE);
  assign done       = done_q;
  assign data_out   = dout_q;
  assign zero       = zero_q;
  assign illegal_op = ill_q;

endmodule

// File: tb/tb_ula_mdu.sv
// Scoreboard bench for ula_mdu: the driver queues expected results, a monitor checks each done.
module tb_ula_mdu;

`ifdef ULA_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [4:0]  select_ula;
  logic [31:0] data1_in, data2_in;
  logic        ready, done, zero, illegal_op;
  logic [31:0] data_out;

  ula_mdu #(.WIDTH(32), .LUI_SHIFT(12)) dut (
    .clk(clk), .reset(reset), .start(start), .select_ula(select_ula),
    .data1_in(data1_in), .data2_in(data2_in), .ready(ready), .done(done),
    .data_out(data_out), .zero(zero), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string       name;
    logic [31:0] data;
    bit          ill;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got %h required %h", nm, got, req);
    end
  endtask

  // Monitor: every done pops one expected transaction
  always @(negedge clk) begin
    if (!reset && done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done got data_out=%h with no transaction pending", data_out);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, "_data"}, data_out, e.data);
        check({e.name, "_zero"}, {31'd0, zero}, {31'd0, (e.data == 32'd0)});
        check({e.name, "_illegal"}, {31'd0, illegal_op}, {31'd0, e.ill});
        check({e.name, "_latency"}, cyc - e.acc, e.lat);
        $display("txn %-8s data_out=%h zero=%b illegal=%b latency=%0d", e.name, data_out, zero,
                 illegal_op, cyc - e.acc);
      end
    end
  end

  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit push, input logic [31:0] ed, input bit eill, input int lat,
                       input string nm);
    int waited;
    exp_t e;
    @(negedge clk);
    select_ula = op;  data1_in = a;  data2_in = b;  start = 1'b1;
    waited = 0;
    while (!ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!ready) begin
      checks++;
      errors++;
      $display("FAIL %s_accept ready got %b required 1 within 200 cycles", nm, ready);
      start = 1'b0;
      return;
    end
    if (push) begin
      e.name = nm;  e.data = ed;  e.ill = eill;  e.lat = lat;  e.acc = cyc + 1;
      sb.push_back(e);
    end
    @(posedge clk);
  endtask

  task automatic drain();
    int waited;
    @(negedge clk);
    start = 1'b0;
    waited = 0;
    while (sb.size() != 0 && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    check("drain_pending", sb.size(), 0);
  endtask

  task automatic check_reset_state(input string nm);
    check({nm, "_data_out"}, data_out, 32'd0);
    check({nm, "_zero"}, {31'd0, zero}, 32'd1);
    check({nm, "_illegal"}, {31'd0, illegal_op}, 32'd0);
    check({nm, "_done"}, {31'd0, done}, 32'd0);
    check({nm, "_ready"}, {31'd0, ready}, 32'd1);
  endtask

  initial begin
    reset = 1'b1;  start = 1'b0;  select_ula = '0;  data1_in = '0;  data2_in = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_reset_state("reset");

    // Base ops
    issue(5'h01, 32'h0000_0005, 32'hFFFF_FFFB, 1, 32'h0000_0000, 0, 1, "ADD");
    issue(5'h07, 32'h8000_0000, 32'd4,         1, 32'hF800_0000, 0, 1, "SRA");
    issue(5'h04, 32'hFFFF_FFFF, 32'd1,         1, 32'h0000_0001, 0, 1, "SLT");
    issue(5'h05, 32'hFFFF_FFFF, 32'd1,         1, 32'h0000_0000, 0, 1, "SLTU");
    issue(5'h0B, 32'd0,         32'h0001_2345, 1, 32'h1234_5000, 0, 1, "LUI");
    // Multiply
    issue(5'h11, 32'h8000_0000, 32'h8000_0000, 1, 32'h4000_0000, 0, MUL_LAT, "MULH");
    issue(5'h13, 32'hFFFF_FFFF, 32'd2,         1, 32'h0000_0001, 0, MUL_LAT, "MULHU");
    issue(5'h10, 32'hFFFF_FFFD, 32'd7,         1, 32'hFFFF_FFEB, 0, MUL_LAT, "MUL");
    issue(5'h12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 0, MUL_LAT, "MULHSU");
    // Divide
    issue(5'h14, 32'hFFFF_FFF9, 32'd2,         1, 32'hFFFF_FFFD, 0, DIV_LAT, "DIV");
    issue(5'h16, 32'hFFFF_FFF9, 32'd2,         1, 32'hFFFF_FFFF, 0, DIV_LAT, "REM");
    issue(5'h15, 32'd100,       32'd7,         1, 32'd14,        0, DIV_LAT, "DIVU");
    issue(5'h17, 32'd100,       32'd7,         1, 32'd2,         0, DIV_LAT, "REMU");
    // Early-outs
    issue(5'h14, 32'hFFFF_FFF9, 32'd0,         1, 32'hFFFF_FFFF, 0, 1, "DIV0");
    issue(5'h17, 32'd9,         32'd0,         1, 32'd9,         0, 1, "REMU0");
    issue(5'h14, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000, 0, 1, "DIVOVF");
    issue(5'h16, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h0000_0000, 0, 1, "REMOVF");
    // Illegal op, then a legal op clears the flag
    issue(5'h01, 32'd3,         32'd4,         1, 32'd7,         0, 1, "ADD7");
    issue(5'h1F, 32'd3,         32'd4,         1, 32'd0,         1, 1, "ILLEGAL");
    issue(5'h01, 32'h10,        32'h20,        1, 32'h30,        0, 1, "ADD30");
    drain();

    // Abort a DIVU with reset; a start while busy must be ignored
    issue(5'h15, 32'd1000, 32'd3, 0, 32'd0, 0, 0, "DIVU_ABORT");
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    select_ula = 5'h01;  data1_in = 32'd1;  data2_in = 32'd2;  start = 1'b1;
    check("busy_ready", {31'd0, ready}, 32'd0);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_reset_state("abort");
    repeat (40) @(negedge clk);
    issue(5'h01, 32'd1, 32'd1, 1, 32'd2, 0, 1, "ADD_POST");
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ula_mdu.md
Name: ula_mdu

Overview:
- Parametrised, registered ALU with an integrated iterative multiply/divide unit (RV32M-class ops) for the TFGRV execute stage.
- Single-cycle base ops (add, sub, shifts, compares, logic, lui) complete one clock after acceptance.
- MUL*/DIV*/REM* ops run a WIDTH-cycle shift-add or restoring-divide sequence.
- A start/ready/done handshake lets the control unit stall while the unit is busy.

Parameters:
- WIDTH, 32: operand/result width; must be >= 16; shift amount uses the low $clog2(WIDTH) bits of data2_in.
- LUI_SHIFT, 12: left shift applied to data2_in for the LUI op.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; accepted only on an edge where ready=1.
- select_ula  input  5  operation code, latched on acceptance.
- data1_in  input  WIDTH  operand A (rs1), latched on acceptance.
- data2_in  input  WIDTH  operand B (rs2/imm), latched on acceptance.
- ready  output  1  high in IDLE; combinational from state.
- done  output  1  one-cycle pulse; data_out, zero and illegal_op are valid in that cycle and held until the next done.
- data_out  output  WIDTH  registered result.
- zero  output  1  registered; 1 when data_out == 0.
- illegal_op  output  1  registered; 1 when the last completed op code was unknown.

Behaviour:
- Reset values: done=0, data_out=0, zero=1, illegal_op=0, state=IDLE, ready=1. Reset mid-operation aborts the sequence; no done is issued for the aborted op.
- Op codes:
  - 0x01 ADD, 0x02 SUB, 0x03 SLL, 0x04 SLT (signed), 0x05 SLTU, 0x06 SRL, 0x07 SRA, 0x08 XOR, 0x09 OR, 0x0A AND, 0x0B LUI (data2_in << LUI_SHIFT).
  - 0x10 MUL (low WIDTH), 0x11 MULH (s×s high), 0x12 MULHSU (s×u high), 0x13 MULHU (u×u high).
  - 0x14 DIV, 0x15 DIVU, 0x16 REM, 0x17 REMU.
  - Any other code: result 0, illegal_op=1, latency 1.
- States: IDLE, MUL, DIV, DONE.
- Start accepted at edge N:
  - Base op or illegal op: goes to DONE; result registered at edge N+1; done high for exactly the cycle after edge N+1; then returns to IDLE.
  - MUL*/DIV*/REM*: operands are converted to magnitudes with recorded signs, then the unit goes to MUL or DIV. A counter runs WIDTH iterations, one bit per cycle. Result sign fix-up and registration happen at edge N+WIDTH+1; done is high in the following cycle.
- Multiply: 2·WIDTH-bit accumulator. MULH* takes the upper half after sign correction. MULHSU treats only A as signed.
- Divide by zero (B==0), detected at acceptance, early-out at latency 1: quotient = all ones, remainder = A (signed and unsigned).
- Signed overflow (A = most negative, B = −1), early-out at latency 1: DIV result = A, REM result = 0.
- Signed REM takes the sign of the dividend.
- start while busy (ready=0) is ignored and does not disturb the latched operands.
- Back-to-back: start may be asserted in the cycle done is high; it is not accepted until ready returns (the IDLE cycle after DONE).
- SLT/SLTU result is zero-extended to WIDTH; shifts use data2_in[$clog2(WIDTH)-1:0].

Optional Feature:
- ULA_FAST_MUL_EN.
- Defined: MUL/MULH/MULHSU/MULHU use a single combinational 2·WIDTH product and follow the base-op path (latency 1; the MUL state is unused).
- Undefined: iterative shift-add multiply, latency WIDTH+1.
- Divide is always iterative in both cases.

Test Plan (WIDTH=32):
- Reset, then ADD with A=0x00000005, B=0xFFFFFFFB -> done one cycle after acceptance; data_out=0, zero=1, illegal_op=0. Same timing for SRA with A=0x80000000, B=4 -> 0xF8000000.
- MULH with A=0x80000000, B=0x80000000 -> 0x40000000, done exactly 33 cycles after acceptance (1 cycle if ULA_FAST_MUL_EN); MULHU with A=0xFFFFFFFF, B=2 -> 0x00000001; MUL with A=−3, B=7 -> 0xFFFFFFEB.
- DIV with A=−7, B=2 -> 0xFFFFFFFD; REM with the same operands -> 0xFFFFFFFF; DIVU with A=100, B=7 -> 14; REMU with the same operands -> 2. Each done after 33 cycles.
- DIV with A=−7, B=0 -> 0xFFFFFFFF; REMU with A=9, B=0 -> 9; DIV with A=0x80000000, B=−1 -> 0x80000000; REM with the same operands -> 0. All with latency 1.
- Start a DIVU, pulse start with ADD operands at cycle 5 (ignored; ready=0), then assert reset at cycle 10 -> no done; outputs equal their reset values; ready=1 on the next cycle; a new ADD completes normally.
- select_ula=0x1F -> done after 1 cycle with data_out=0, zero=1, illegal_op=1. A following valid op clears illegal_op at its done.
